i2c_meas_scheduler: RTL

//  Sequences the I2C measurement engine (measure/done/16-bit data handshake).

---
 rtl/i2c_meas_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/i2c_meas_scheduler.sv
// i2c_meas_scheduler
// Starts I2C measurements on a periodic tick or on a host request. Each
// transaction has a timeout; after a timeout the engine gets a recovery
// reset and the measurement is retried. The last good sample is held for
// the system bus, and a sticky error flags a transaction that used up all
// of its retries.
module i2c_meas_scheduler #(
    parameter int PERIOD_CYC  = 50_000_000,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int RST_CYC     = 16,
    parameter int MAX_RETRY   = 3,
    parameter int DATA_W      = 16
) (
    input  logic              mclk,
    input  logic              resetG,
    input  logic              enable,
    input  logic              host_req,
    input  logic              err_clr,
    input  logic              i2c_done,
    input  logic [DATA_W-1:0] i2c_data,
    output logic              measure,
    output logic              eng_reset,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              host_ack,
    output logic              err,
    output logic [1:0]        retry_cnt
);

    localparam int PER_W = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RC_W  = (RST_CYC     > 1) ? $clog2(RST_CYC)     : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t            state;
    logic [PER_W-1:0]  per_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [RC_W-1:0]   rc_cnt;
    logic              pend_host;
    logic              pend_per;
    logic              txn_host;
    logic              tick;
    logic              to_hit;
    logic              exhaust;

    assign tick    = enable && (per_cnt == PER_W'(PERIOD_CYC - 1));
    assign to_hit  = (state == S_WAIT) && !i2c_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign exhaust = to_hit && (int'(retry_cnt) >= MAX_RETRY);

    // Free-running period counter while enabled, parked at zero otherwise.
    always_ff @(posedge mclk or posedge resetG) begin
        if (resetG) begin
            per_cnt <= '0;
        end else if (!enable || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Transaction sequencer: issue, watch for done/timeout, recover and retry.
    always_ff @(posedge mclk or posedge resetG) begin
        if (resetG) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            rc_cnt       <= '0;
            pend_host    <= 1'b0;
            pend_per     <= 1'b0;
            txn_host     <= 1'b0;
            measure      <= 1'b0;
            eng_reset    <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            host_ack     <= 1'b0;
            err          <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            measure      <= 1'b0;
            result_valid <= 1'b0;
            host_ack     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pend_host || pend_per) begin
                        state     <= S_ISSUE;
                        measure   <= 1'b1;
                        busy      <= 1'b1;
                        txn_host  <= pend_host;
                        pend_host <= 1'b0;
                        pend_per  <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        result       <= i2c_data;
                        result_valid <= 1'b1;
                        host_ack     <= txn_host;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (to_hit) begin
                        if (exhaust) begin
                            host_ack <= txn_host;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 2'd1;
                            eng_reset <= 1'b1;
                            rc_cnt    <= '0;
                            state     <= S_RECOVER;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (rc_cnt == RC_W'(RST_CYC - 1)) begin
                        eng_reset <= 1'b0;
                        measure   <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        rc_cnt <= rc_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // New requests land after the IDLE clear so a same-cycle arrival stays pending.
            if (host_req) pend_host <= 1'b1;
            if (tick)     pend_per  <= 1'b1;
            // Setting the error outranks clearing it.
            err <= exhaust | (err & ~err_clr);
        end
    end

endmodule
